// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: clock inhibit, request-to-send, 11-bit frame and ACK check.
// Optional watchdog abort is compiled in when PS2_TX_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned INHIBIT_US  = 100,
  parameter int unsigned TIMEOUT_MS  = 15
) (
  input  logic       iCLK_50,
  input  logic       iRST,
  input  logic       iSTART,
  input  logic [7:0] iDATA,
  input  logic       iPS2_CLK,
  input  logic       iPS2_DAT,
  output logic       oPS2_CLK_OE,
  output logic       oPS2_DAT_OE,
  output logic       oBUSY,
  output logic       oDONE,
  output logic       oACK_ERR,
  output logic       oTIMEOUT
);

  localparam int unsigned INHIBIT_CYC = (CLK_FREQ_HZ / 1_000_000) * INHIBIT_US;
  localparam int unsigned INH_W       = $clog2(INHIBIT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, XFER, ACK, WAIT_IDLE, DONE
  } state_t;

  state_t           state;
  logic [1:0]       clk_sync;
  logic [1:0]       dat_sync;
  logic             clk_d;
  logic [INH_W-1:0] inh_cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       data_q;
  logic             parity_q;
  logic             fall_c;
  logic             line_idle_c;

  // Pad synchronizers; reset to the idle-high line level so reset never fakes an edge
  always_ff @(posedge iCLK_50 or posedge iRST) begin
    if (iRST) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_d    <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], iPS2_CLK};
      dat_sync <= {dat_sync[0], iPS2_DAT};
      clk_d    <= clk_sync[1];
    end
  end

  assign fall_c      = clk_d & ~clk_sync[1];
  assign line_idle_c = clk_sync[1] & dat_sync[1];

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYC = (CLK_FREQ_HZ / 1000) * TIMEOUT_MS;
  localparam int unsigned WD_W        = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wdog;
  logic            wd_active_c;
  logic            wd_abort_c;

  assign wd_active_c = (state == XFER) || (state == ACK) || (state == WAIT_IDLE);
  // A falling edge or line-idle completion in the expiry cycle still counts as progress
  assign wd_abort_c  = wd_active_c && (wdog == WD_W'(TIMEOUT_CYC - 1)) && !fall_c &&
                       !((state == WAIT_IDLE) && line_idle_c);

  // Watchdog: cleared outside the device-clocked states and on every falling edge
  always_ff @(posedge iCLK_50 or posedge iRST) begin
    if (iRST) begin
      wdog <= '0;
    end else if (!wd_active_c || fall_c) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + WD_W'(1);
    end
  end
`else
  assign oTIMEOUT = 1'b0;
`endif

  // Transaction FSM with registered line enables and status
  always_ff @(posedge iCLK_50 or posedge iRST) begin
    if (iRST) begin
      state       <= IDLE;
      oPS2_CLK_OE <= 1'b0;
      oPS2_DAT_OE <= 1'b0;
      oBUSY       <= 1'b0;
      oDONE       <= 1'b0;
      oACK_ERR    <= 1'b0;
      inh_cnt     <= '0;
      bit_cnt     <= '0;
      data_q      <= '0;
      parity_q    <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      oTIMEOUT    <= 1'b0;
`endif
    end else begin
      oDONE <= 1'b0;
      case (state)
        IDLE: begin
          if (iSTART) begin
            data_q      <= iDATA;
            parity_q    <= ~^iDATA;
            oBUSY       <= 1'b1;
            oPS2_CLK_OE <= 1'b1;
            oACK_ERR    <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            oTIMEOUT    <= 1'b0;
`endif
            inh_cnt     <= '0;
            bit_cnt     <= '0;
            state       <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (inh_cnt == INH_W'(INHIBIT_CYC - 1)) begin
            oPS2_DAT_OE <= 1'b1;
            state       <= RTS;
          end else begin
            inh_cnt <= inh_cnt + INH_W'(1);
          end
        end
        RTS: begin
          oPS2_CLK_OE <= 1'b0;
          bit_cnt     <= '0;
          state       <= XFER;
        end
        XFER: begin
          // bit_cnt holds edges seen so far; edge k+1 drives data bit k
          if (fall_c) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt < 4'd8) begin
              oPS2_DAT_OE <= ~data_q[bit_cnt[2:0]];
            end else if (bit_cnt == 4'd8) begin
              oPS2_DAT_OE <= ~parity_q;
            end else begin
              oPS2_DAT_OE <= 1'b0;
              state       <= ACK;
            end
          end
        end
        ACK: begin
          if (fall_c) begin
            oACK_ERR <= dat_sync[1];
            state    <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (line_idle_c) begin
            oDONE <= 1'b1;
            oBUSY <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      if (wd_abort_c) begin
        oPS2_CLK_OE <= 1'b0;
        oPS2_DAT_OE <= 1'b0;
        oDONE       <= 1'b1;
        oBUSY       <= 1'b0;
        oACK_ERR    <= 1'b1;
        oTIMEOUT    <= 1'b1;
        state       <= DONE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// checks inhibit timing, frame bits, parity, ACK status, busy/reset handling and the watchdog.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int unsigned CLK_HZ  = 2_000_000;
  localparam int unsigned INH_US  = 100;
  localparam int unsigned TO_MS   = 1;
  localparam int unsigned INH_CYC = 200;   // 2 cycles/us * 100 us
  localparam int unsigned TO_CYC  = 2000;  // 2000 cycles/ms * 1 ms
  localparam int unsigned HALF    = 80;    // half period of a 12.5 kHz device clock at 2 MHz

  typedef struct packed {
    logic ack_err;
    logic tmo;
  } res_t;

  logic       iCLK_50 = 1'b0;
  logic       iRST    = 1'b1;
  logic       iSTART  = 1'b0;
  logic [7:0] iDATA   = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       oPS2_CLK_OE, oPS2_DAT_OE, oBUSY, oDONE, oACK_ERR, oTIMEOUT;
  logic       ps2_clk, ps2_dat;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int done_cnt  = 0;

  logic [7:0] exp_q[$];
  res_t       res_q[$];

  // Open-collector bus: either side can pull a line low
  assign ps2_clk = ~oPS2_CLK_OE & dev_clk;
  assign ps2_dat = ~oPS2_DAT_OE & dev_dat;

  ps2_host_tx #(
    .CLK_FREQ_HZ(CLK_HZ),
    .INHIBIT_US (INH_US),
    .TIMEOUT_MS (TO_MS)
  ) dut (
    .iCLK_50    (iCLK_50),
    .iRST       (iRST),
    .iSTART     (iSTART),
    .iDATA      (iDATA),
    .iPS2_CLK   (ps2_clk),
    .iPS2_DAT   (ps2_dat),
    .oPS2_CLK_OE(oPS2_CLK_OE),
    .oPS2_DAT_OE(oPS2_DAT_OE),
    .oBUSY      (oBUSY),
    .oDONE      (oDONE),
    .oACK_ERR   (oACK_ERR),
    .oTIMEOUT   (oTIMEOUT)
  );

  always #5 iCLK_50 = ~iCLK_50;

  always @(posedge iCLK_50) cyc <= cyc + 1;

  always @(negedge iCLK_50) if (oDONE) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Issue a request at the current negedge and record what the bus must show
  task automatic send(input logic [7:0] d, input logic exp_ack_err, input logic exp_tmo);
    res_t r;
    iDATA  = d;
    iSTART = 1'b1;
    exp_q.push_back(d);
    r.ack_err = exp_ack_err;
    r.tmo     = exp_tmo;
    res_q.push_back(r);
    @(negedge iCLK_50);
    iSTART = 1'b0;
    check("busy_after_start", {31'd0, oBUSY}, 32'd1);
    check("clk_oe_after_start", {31'd0, oPS2_CLK_OE}, 32'd1);
  endtask

  // Device model: measures the inhibit, clocks up to last_edge falling edges, optionally
  // acknowledges, optionally resets the host at rst_edge, then scores the frame and result.
  task automatic run_frame(input logic ack, input int last_edge, input logic poke, input int rst_edge);
    int         n;
    int         t_fall;
    logic [9:0] bits;
    logic [7:0] ed;
    res_t       r;
    bits   = '0;
    t_fall = 0;
    n      = 0;
    while (oPS2_CLK_OE && !oPS2_DAT_OE && n < 4 * INH_CYC) begin
      n++;
      if (poke && n == 10) begin
        iDATA  = 8'hAA;
        iSTART = 1'b1;
      end
      @(negedge iCLK_50);
      iSTART = 1'b0;
    end
    check("inhibit_len", n, INH_CYC);
    check("rts_lines", {30'd0, oPS2_CLK_OE, oPS2_DAT_OE}, 32'd3);
    @(negedge iCLK_50);
    check("xfer_entry_lines", {30'd0, oPS2_CLK_OE, oPS2_DAT_OE}, 32'd1);
    for (int e = 1; e <= 11; e++) begin
      repeat (HALF) @(negedge iCLK_50);
      dev_clk = 1'b0;
      t_fall  = cyc;
      if (e == rst_edge) begin
        repeat (6) @(negedge iCLK_50);
        check("pre_rst_dat_oe", {31'd0, oPS2_DAT_OE}, 32'd1);
        iRST = 1'b1;
        #1;
        check("rst_clk_oe", {31'd0, oPS2_CLK_OE}, 32'd0);
        check("rst_dat_oe", {31'd0, oPS2_DAT_OE}, 32'd0);
        dev_clk = 1'b1;
        void'(exp_q.pop_front());
        void'(res_q.pop_front());
        return;
      end
      repeat (HALF) @(negedge iCLK_50);
      if (e <= 10) bits[e-1] = ps2_dat;
      dev_clk = 1'b1;
      if (e == 10 && ack) dev_dat = 1'b0;
      if (e == 11) dev_dat = 1'b1;
      if (e == last_edge) break;
    end
    ed = exp_q.pop_front();
    if (last_edge == 11) begin
      check("frame_data", {24'd0, bits[7:0]}, {24'd0, ed});
      check("frame_parity", {31'd0, bits[8]}, {31'd0, ($countones(ed) % 2 == 0)});
      check("frame_stop", {31'd0, bits[9]}, 32'd1);
    end else begin
      check("partial_data", {28'd0, bits[3:0]}, {28'd0, ed[3:0]});
    end
    n = 0;
    while (!oDONE && n < 2 * TO_CYC + 1000) begin
      @(negedge iCLK_50);
      n++;
    end
    r = res_q.pop_front();
    check("done_seen", {31'd0, oDONE}, 32'd1);
    check("ack_err", {31'd0, oACK_ERR}, {31'd0, r.ack_err});
    check("timeout_flag", {31'd0, oTIMEOUT}, {31'd0, r.tmo});
    check("busy_at_done", {31'd0, oBUSY}, 32'd0);
    if (last_edge < 11) begin
      check("timeout_latency", cyc - t_fall, TO_CYC + 3);
      check("timeout_lines", {30'd0, oPS2_CLK_OE, oPS2_DAT_OE}, 32'd0);
    end
    @(negedge iCLK_50);
    check("done_one_cycle", {31'd0, oDONE}, 32'd0);
  endtask

  initial begin
    int pre_done;
    repeat (3) @(negedge iCLK_50);
    check("rst_clk_oe_init", {31'd0, oPS2_CLK_OE}, 32'd0);
    check("rst_dat_oe_init", {31'd0, oPS2_DAT_OE}, 32'd0);
    check("rst_busy", {31'd0, oBUSY}, 32'd0);
    check("rst_done", {31'd0, oDONE}, 32'd0);
    check("rst_ack_err", {31'd0, oACK_ERR}, 32'd0);
    check("rst_timeout", {31'd0, oTIMEOUT}, 32'd0);
    iRST = 1'b0;
    repeat (5) @(negedge iCLK_50);

    // Normal send with an ignored second request during the inhibit
    send(8'hF4, 1'b0, 1'b0);
    run_frame(1'b1, 11, 1'b1, 0);
    repeat (20) @(negedge iCLK_50);
    check("no_second_tx", {31'd0, oBUSY}, 32'd0);

    send(8'hFF, 1'b0, 1'b0);
    run_frame(1'b1, 11, 1'b0, 0);
    repeat (10) @(negedge iCLK_50);
    send(8'h00, 1'b0, 1'b0);
    run_frame(1'b1, 11, 1'b0, 0);
    repeat (10) @(negedge iCLK_50);
    // Device never pulls data low for the ACK
    send(8'h01, 1'b1, 1'b0);
    run_frame(1'b0, 11, 1'b0, 0);
    repeat (10) @(negedge iCLK_50);

    // Reset mid-transfer, then start on the first cycle out of reset
    send(8'hF4, 1'b0, 1'b0);
    pre_done = done_cnt;
    run_frame(1'b1, 11, 1'b0, 2);
    repeat (3) @(negedge iCLK_50);
    iRST = 1'b0;
    send(8'h5A, 1'b0, 1'b0);
    run_frame(1'b1, 11, 1'b0, 0);
    check("done_count_after_abort", done_cnt, pre_done + 1);

`ifdef PS2_TX_TIMEOUT_EN
    repeat (10) @(negedge iCLK_50);
    send(8'h12, 1'b1, 1'b1);
    run_frame(1'b1, 4, 1'b0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
